// File: rtl/spi_cmd_queue_if.sv
// Command-queue bundle: the control-side write port, status/error flags and the SPI master handshake.
// The queue uses the master modport; whatever drives commands and models the SPI master uses slave.
interface spi_cmd_queue_if #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 8,
  parameter int CLK_RATIO = 8,
  parameter int DEPTH     = 8
);
  localparam int LVL_BITS = $clog2(DEPTH) + 1;

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [LVL_BITS-1:0]  level;
  logic [CLK_RATIO-1:0] cfg_ratio;
  logic                 clear_err;
  logic                 overflow;
  logic                 timeout_err;
  logic                 idle_o;
  logic                 spi_start;
  logic [ADDR_BITS-1:0] spi_address;
  logic [DATA_BITS-1:0] spi_data;
  logic [CLK_RATIO-1:0] spi_ratio;
  logic                 spi_busy;
  logic                 spi_done;

  modport master (
    input  wr_en, wr_addr, wr_data, cfg_ratio, clear_err, spi_busy, spi_done,
    output full, empty, level, overflow, timeout_err, idle_o,
           spi_start, spi_address, spi_data, spi_ratio
  );

  modport slave (
    output wr_en, wr_addr, wr_data, cfg_ratio, clear_err, spi_busy, spi_done,
    input  full, empty, level, overflow, timeout_err, idle_o,
           spi_start, spi_address, spi_data, spi_ratio
  );
endinterface

// File: rtl/spi_cmd_queue.sv
// Queues address/data writes and feeds them one at a time to the SPI write master; launch is 2 cycles after push.
// Pushes while full are dropped and flagged; a launch the master never acknowledges with busy is discarded and flagged.
module spi_cmd_queue #(
  parameter int DATA_BITS    = 16,
  parameter int ADDR_BITS    = 8,
  parameter int CLK_RATIO    = 8,
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  spi_cmd_queue_if.master  bus
);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam int CNT_BITS = $clog2(BUSY_TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  cmd_t                 mem [DEPTH];
  cmd_t                 head;
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic [LVL_BITS-1:0]  count;
  logic [LVL_BITS-1:0]  count_nxt;
  logic                 full_q;
  logic                 empty_q;
  logic                 push;
  logic                 pop;

  state_t               state;
  logic [CNT_BITS-1:0]  busy_cnt;
  logic                 busy_expire;
  logic                 timeout_evt;
  logic                 start_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic [CLK_RATIO-1:0] ratio_q;
  logic                 overflow_q;
  logic                 timeout_q;

  // full is the registered flag, so a pop in the same cycle cannot make room for a push
  assign push = bus.wr_en && !full_q;
  assign head = mem[rd_ptr];

  assign busy_expire = (busy_cnt == CNT_BITS'(BUSY_TIMEOUT - 1));
  assign timeout_evt = (state == WAIT_BUSY) && !bus.spi_busy && busy_expire;
  assign pop         = timeout_evt || ((state == WAIT_DONE) && bus.spi_done);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + LVL_BITS'(1);
      2'b01:   count_nxt = count - LVL_BITS'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count   <= count_nxt;
      full_q  <= (count_nxt == LVL_BITS'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // The head entry stays queued while in flight; it is popped only on done or timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy_cnt <= '0;
      start_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ratio_q  <= CLK_RATIO'(CLK_RATIO - 1);
    end else begin
      case (state)
        IDLE: begin
          if (!empty_q) begin
            addr_q  <= head.addr;
            data_q  <= head.data;
            ratio_q <= (bus.cfg_ratio < CLK_RATIO'(2)) ? CLK_RATIO'(2) : bus.cfg_ratio;
            start_q <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_q  <= 1'b0;
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.spi_busy) begin
            state <= WAIT_DONE;
          end else begin
            busy_cnt <= busy_cnt + CNT_BITS'(1);
            if (busy_expire) state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (bus.spi_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh error event takes priority over clear_err in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (bus.wr_en && full_q)  overflow_q <= 1'b1;
      else if (bus.clear_err)   overflow_q <= 1'b0;
      if (timeout_evt)          timeout_q  <= 1'b1;
      else if (bus.clear_err)   timeout_q  <= 1'b0;
    end
  end

  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.level       = count;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;
  assign bus.idle_o      = (state == IDLE) && empty_q;
  assign bus.spi_start   = start_q;
  assign bus.spi_address = addr_q;
  assign bus.spi_data    = data_q;
  assign bus.spi_ratio   = ratio_q;

endmodule
